cp0_exception_unit: RTL and testbench

Coprocessor-0 state holder and exception sequencer for the pipelined MIPS core. It consumes the cause/control strobes produced by the main decoder: int_cause, cause_write, exit_kernel and write_c0. It tracks user/kernel mode, holds the Status, Cause and EPC registers, and issues a one-cycle PC redirect to the exception vector. It also supplies kernel_mode back to the decoder and serves mfc0 reads.

---
 rtl/cp0_exception_unit.sv | 127 ++++++++++++
 tb/tb_cp0_exception_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 state and exception sequencer: user/kernel/halt mode, Status/Cause/EPC,
// one-cycle fetch redirect on exception entry, and combinational mfc0 reads.
module cp0_exception_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter logic [2:0]  IRQ_CODE   = 3'b100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  int_cause,
  input  logic        cause_write,
  input  logic        exit_kernel,
  input  logic        write_c0,
  input  logic [4:0]  c0_addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc_exc,
  input  logic        stall,
  input  logic        ext_irq,
  output logic        kernel_mode,
  output logic [31:0] rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        halted
);

  localparam logic [1:0] S_USER   = 2'd0;
  localparam logic [1:0] S_KERNEL = 2'd1;
  localparam logic [1:0] S_HALT   = 2'd2;

  localparam logic [4:0] A_STATUS = 5'd12;
  localparam logic [4:0] A_CAUSE  = 5'd13;
  localparam logic [4:0] A_EPC    = 5'd14;

  logic [1:0]  state_q, state_d;
  logic        ie_q, ie_d, pie_q, pie_d;
  logic [2:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic        irq_m_q, irq_m_d, irq_s_q, irq_s_d;
  logic        redir_q, redir_d;
  logic        halted_q, halted_d;

  always_comb begin
    state_d  = state_q;
    ie_d     = ie_q;
    pie_d    = pie_q;
    code_d   = code_q;
    epc_d    = epc_q;
    irq_m_d  = irq_m_q;
    irq_s_d  = irq_s_q;
    redir_d  = 1'b0;
    halted_d = halted_q;
    if (!stall) begin
      irq_m_d = ext_irq;
      irq_s_d = irq_m_q;
      case (state_q)
        S_USER: begin
          // Decoder exceptions outrank the interrupt; mtc0/eret are ignored here.
          if (cause_write || (irq_s_q && ie_q)) begin
            epc_d   = pc_exc;
            code_d  = cause_write ? int_cause : IRQ_CODE;
            pie_d   = ie_q;
            ie_d    = 1'b0;
            state_d = S_KERNEL;
            redir_d = 1'b1;
          end
        end
        S_KERNEL: begin
          if (cause_write) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            code_d   = int_cause;
          end else begin
            if (write_c0 && c0_addr == A_STATUS) begin
              ie_d  = wdata[0];
              pie_d = wdata[1];
            end
            if (write_c0 && c0_addr == A_EPC) epc_d = wdata;
            // Exit restores IE from the old PIE even if mtc0 Status lands the same cycle.
            if (exit_kernel) begin
              state_d = S_USER;
              ie_d    = pie_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_USER;
      ie_q     <= 1'b0;
      pie_q    <= 1'b0;
      code_q   <= 3'd0;
      epc_q    <= 32'd0;
      irq_m_q  <= 1'b0;
      irq_s_q  <= 1'b0;
      redir_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ie_q     <= ie_d;
      pie_q    <= pie_d;
      code_q   <= code_d;
      epc_q    <= epc_d;
      irq_m_q  <= irq_m_d;
      irq_s_q  <= irq_s_d;
      redir_q  <= redir_d;
      halted_q <= halted_d;
    end
  end

  assign kernel_mode    = (state_q != S_USER);
  assign halted         = halted_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = redir_q ? EXC_VECTOR : 32'd0;

  always_comb begin
    case (c0_addr)
      A_STATUS: rdata = {30'd0, pie_q, ie_q};
      A_CAUSE:  rdata = {23'd0, irq_s_q, 5'd0, code_q};
      A_EPC:    rdata = epc_q;
      default:  rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed bench for cp0_exception_unit: entry, mtc0/eret, interrupt, stall, double fault, reset.
module tb_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  int_cause;
  logic        cause_write, exit_kernel, write_c0, stall, ext_irq;
  logic [4:0]  c0_addr;
  logic [31:0] wdata, pc_exc;
  logic        kernel_mode, redirect_valid, halted;
  logic [31:0] rdata, redirect_pc;

  int checks = 0;
  int errors = 0;

  cp0_exception_unit dut (
    .clk(clk), .reset(reset), .int_cause(int_cause), .cause_write(cause_write),
    .exit_kernel(exit_kernel), .write_c0(write_c0), .c0_addr(c0_addr), .wdata(wdata),
    .pc_exc(pc_exc), .stall(stall), .ext_irq(ext_irq), .kernel_mode(kernel_mode),
    .rdata(rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cause_write = 0; exit_kernel = 0; write_c0 = 0; stall = 0;
  endtask

  task automatic rd(input logic [4:0] a);
    c0_addr = a;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1; idle(); ext_irq = 0; int_cause = 0; c0_addr = 0; wdata = 0; pc_exc = 0;
    step();
    chk("rst_kernel", {31'd0, kernel_mode}, 0);
    chk("rst_redir", {31'd0, redirect_valid}, 0);
    chk("rst_redir_pc", redirect_pc, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    rd(12); chk("rst_status", rdata, 0);
    rd(13); chk("rst_cause", rdata, 0);
    rd(14); chk("rst_epc", rdata, 0);
    reset = 0;
    step();
  endtask

  task automatic test_user_ignore();
    write_c0 = 1; c0_addr = 12; wdata = 3; exit_kernel = 1;
    step(); idle();
    rd(12); chk("user_ign_status", rdata, 0);
    chk("user_ign_kernel", {31'd0, kernel_mode}, 0);
    chk("user_ign_redir", {31'd0, redirect_valid}, 0);
  endtask

  task automatic test_entry();
    cause_write = 1; int_cause = 1; pc_exc = 32'h40;
    step(); idle();
    chk("entry_redir", {31'd0, redirect_valid}, 1);
    chk("entry_redir_pc", redirect_pc, 32'h180);
    chk("entry_kernel", {31'd0, kernel_mode}, 1);
    rd(14); chk("entry_epc", rdata, 32'h40);
    rd(13); chk("entry_cause", rdata, 1);
    rd(12); chk("entry_status", rdata, 0);
    rd(5);  chk("entry_rd_other", rdata, 0);
    step();
    chk("entry_pulse_end", {31'd0, redirect_valid}, 0);
    chk("entry_pc_end", redirect_pc, 0);
  endtask

  task automatic test_mtc0_exit();
    write_c0 = 1; c0_addr = 14; wdata = 32'h100;
    step(); idle();
    rd(14); chk("mtc0_epc", rdata, 32'h100);
    write_c0 = 1; c0_addr = 13; wdata = 32'hff;
    step(); idle();
    rd(13); chk("mtc0_cause_ro", rdata, 1);
    exit_kernel = 1;
    step(); idle();
    chk("exit_kernel", {31'd0, kernel_mode}, 0);
    chk("exit_no_redir", {31'd0, redirect_valid}, 0);
    rd(14); chk("exit_epc", rdata, 32'h100);
    rd(12); chk("exit_status", rdata, 0);
    // Re-enter, arm PIE so the exit enables interrupts.
    cause_write = 1; int_cause = 2; pc_exc = 32'h44;
    step(); idle();
    write_c0 = 1; c0_addr = 12; wdata = 2;
    step(); idle();
    rd(12); chk("mtc0_status", rdata, 2);
    exit_kernel = 1;
    step(); idle();
    rd(12); chk("exit_ie_restored", rdata, 3);
    chk("exit2_kernel", {31'd0, kernel_mode}, 0);
  endtask

  task automatic test_irq();
    pc_exc = 32'h200; ext_irq = 1;
    step();
    chk("irq_e1_kernel", {31'd0, kernel_mode}, 0);
    rd(13); chk("irq_e1_cause", rdata, 2);
    step();
    chk("irq_e2_kernel", {31'd0, kernel_mode}, 0);
    rd(13); chk("irq_e2_cause", rdata, 32'h102);
    step();
    ext_irq = 0;
    chk("irq_redir", {31'd0, redirect_valid}, 1);
    chk("irq_kernel", {31'd0, kernel_mode}, 1);
    rd(13); chk("irq_cause", rdata, 32'h104);
    rd(14); chk("irq_epc", rdata, 32'h200);
    rd(12); chk("irq_status", rdata, 2);
    step(); step();
    chk("irq_kernel_hold", {31'd0, kernel_mode}, 1);
    rd(13); chk("irq_sync_clear", rdata, 4);
    // Exit and mtc0 Status together: IE from old PIE, PIE from wdata[1].
    exit_kernel = 1; write_c0 = 1; c0_addr = 12; wdata = 0;
    step(); idle();
    rd(12); chk("exit_mtc0_status", rdata, 1);
    chk("exit_mtc0_kernel", {31'd0, kernel_mode}, 0);
  endtask

  task automatic test_stall();
    stall = 1; cause_write = 1; int_cause = 3; pc_exc = 32'h300;
    step(); step();
    chk("stall_kernel", {31'd0, kernel_mode}, 0);
    chk("stall_redir", {31'd0, redirect_valid}, 0);
    rd(14); chk("stall_epc", rdata, 32'h200);
    stall = 0;
    step(); idle();
    chk("unstall_redir", {31'd0, redirect_valid}, 1);
    chk("unstall_kernel", {31'd0, kernel_mode}, 1);
    rd(14); chk("unstall_epc", rdata, 32'h300);
    rd(13); chk("unstall_cause", rdata, 3);
    rd(12); chk("unstall_status", rdata, 2);
    stall = 1; exit_kernel = 1;
    step(); idle();
    chk("stall_exit_kernel", {31'd0, kernel_mode}, 1);
  endtask

  task automatic test_double_fault();
    cause_write = 1; int_cause = 1; exit_kernel = 1; pc_exc = 32'h500;
    step(); idle();
    chk("df_halted", {31'd0, halted}, 1);
    chk("df_kernel", {31'd0, kernel_mode}, 1);
    chk("df_no_redir", {31'd0, redirect_valid}, 0);
    rd(14); chk("df_epc", rdata, 32'h300);
    rd(13); chk("df_cause", rdata, 1);
    exit_kernel = 1; write_c0 = 1; c0_addr = 14; wdata = 32'hdead;
    step(); idle();
    cause_write = 1; int_cause = 2;
    step(); idle();
    chk("halt_kernel", {31'd0, kernel_mode}, 1);
    chk("halt_halted", {31'd0, halted}, 1);
    chk("halt_no_redir", {31'd0, redirect_valid}, 0);
    rd(14); chk("halt_epc", rdata, 32'h300);
    rd(13); chk("halt_cause", rdata, 1);
    #2 reset = 1; #1;
    chk("halt_rst_halted", {31'd0, halted}, 0);
    chk("halt_rst_kernel", {31'd0, kernel_mode}, 0);
    rd(14); chk("halt_rst_epc", rdata, 0);
    step(); reset = 0; step();
  endtask

  task automatic test_reset_mid_redirect();
    cause_write = 1; int_cause = 2; pc_exc = 32'h80;
    step(); idle();
    chk("mid_redir_set", {31'd0, redirect_valid}, 1);
    #2 reset = 1; #1;
    chk("mid_redir_drop", {31'd0, redirect_valid}, 0);
    chk("mid_redir_pc", redirect_pc, 0);
    chk("mid_kernel", {31'd0, kernel_mode}, 0);
    step(); reset = 0; step();
  endtask

  initial begin
    test_reset();
    test_user_ignore();
    test_entry();
    test_mtc0_exit();
    test_irq();
    test_stall();
    test_double_fault();
    test_reset_mid_redirect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
